// File: rtl/pulse_generator_pkg.sv
// Shared constants and helpers for the mode-selectable PWM source.
// Counter width is fixed at 16 bits, so PERIOD can go up to 65536.
package pulse_generator_pkg;

  localparam int PWM_STEP   = 4;
  localparam int PWM_PERIOD = 64;
  localparam int CNT_W      = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // mode*step in counter width; the parameter check keeps the product below PERIOD
  function automatic cnt_t scale_duty(input logic [3:0] mode, input int step);
    return cnt_t'(mode) * cnt_t'(step);
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter with a wrap at PERIOD-1 and a terminal-count strobe.
// The next-count value (not including reset) is exported so the parent can register pwm from it.
module pwm_period_counter
  import pulse_generator_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic clk,
  input  logic rst,
  output cnt_t o_count,
  output cnt_t o_count_next,
  output logic o_wrap
);

  localparam cnt_t LAST = cnt_t'(PERIOD - 1);

  cnt_t r_count;
  cnt_t w_count_next;
  logic w_wrap;

  assign w_wrap       = (r_count == LAST);
  assign w_count_next = w_wrap ? '0 : r_count + cnt_t'(1);

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_count_next;
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_wrap       = w_wrap;

endmodule

// File: rtl/pulse_generator.sv
// Mode-selectable PWM: duty reloads from mode only at the period wrap, so pulses are never runt or stretched.
// pwm is registered from next-state count/duty, keeping it cycle-aligned with count and glitch-free.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int STEP   = PWM_STEP,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  output logic        pwm,
  output logic [15:0] count,
  output logic        maxbitwidth
);

  generate
    if (STEP < 1 || PERIOD < 16 * STEP || PERIOD > 65536) begin : g_param_check
      $error("pulse_generator: need STEP>=1 and 16*STEP <= PERIOD <= 65536");
    end
  endgenerate

  cnt_t w_count;
  cnt_t w_count_next;
  cnt_t w_duty_next;
  logic w_wrap;
  cnt_t r_duty;
  logic r_pwm;

  pwm_period_counter #(
    .PERIOD(PERIOD)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .o_count     (w_count),
    .o_count_next(w_count_next),
    .o_wrap      (w_wrap)
  );

  assign w_duty_next = w_wrap ? scale_duty(mode, STEP) : r_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_duty <= w_duty_next;
      r_pwm  <= (w_count_next < w_duty_next);
    end
  end

  assign pwm         = r_pwm;
  assign count       = w_count;
  assign maxbitwidth = w_wrap;

endmodule

// File: tb/tb_pulse_generator.sv
// Scoreboard bench for pulse_generator: a cycle-level reference model pushes expected outputs
// after each clock edge and a negedge monitor pops and compares them.
module tb_pulse_generator;

  localparam int STEP   = 4;
  localparam int PERIOD = 64;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  mode = 4'd0;
  logic        pwm;
  logic [15:0] count;
  logic        maxbitwidth;

  always #5 clk = ~clk;

  pulse_generator #(
    .STEP  (STEP),
    .PERIOD(PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .pwm        (pwm),
    .count      (count),
    .maxbitwidth(maxbitwidth)
  );

  typedef struct {
    int c;
    bit p;
    bit t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: cycles elapsed since reset and the high time chosen at the latest period start
  int m_t    = 0;
  int m_high = 0;

  function automatic int model_count();
    return m_t % PERIOD;
  endfunction

  task automatic model_edge(input bit r, input int m);
    exp_t e;
    if (r) begin
      m_t    = 0;
      m_high = 0;
    end else begin
      m_t = m_t + 1;
      if (m_t % PERIOD == 0) m_high = m * STEP;
    end
    e.c = m_t % PERIOD;
    e.p = (e.c < m_high);
    e.t = (e.c == PERIOD - 1);
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input int m);
    rst  = r;
    mode = 4'(m);
    @(posedge clk);
    model_edge(r, m);
    #1;
  endtask

  task automatic run(input bit r, input int m, input int n);
    for (int i = 0; i < n; i++) step(r, m);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("count", {16'd0, count}, e.c);
      chk("pwm", {31'd0, pwm}, {31'd0, e.p});
      chk("maxbitwidth", {31'd0, maxbitwidth}, {31'd0, e.t});
    end
  end

  initial begin
    int m;
    bit r;

    run(1, 4, 150);

    run(0, 1, 3 * PERIOD);

    while (model_count() != 20) step(0, 1);
    run(0, 2, 2 * PERIOD + 10);

    run(0, 3, 2 * PERIOD);
    run(0, 4, 2 * PERIOD);
    run(0, 0, 3 * PERIOD);

    run(0, 15, 3 * PERIOD);

    run(0, 4, PERIOD);
    while (model_count() != 2) step(0, 4);
    step(1, 4);
    run(0, 4, 3 * PERIOD);

    m = 5;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) m = $urandom_range(0, 15);
      r = ($urandom_range(0, 149) == 0);
      step(r, m);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
Mode-selectable PWM source. A free-running period counter is compared against a duty threshold derived from the 4-bit `mode` input, producing a glitch-free `pwm` waveform. The block also exposes the counter value and a terminal-count strobe (`maxbitwidth`) for debug and for synchronising downstream logic. It sits as a leaf block driven directly by a system clock and control register or switches.

Parameters:
- STEP, default 4: high-time cycles per mode unit. Must be ≥1.
- PERIOD, default 64: PWM period in clock cycles.
  - Must satisfy 16*STEP ≤ PERIOD ≤ 65536.
  - Elaboration-time check rejects violations.

Ports:
- clk  input  1: single system clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- mode  input  4: duty select. 0 = off; m = m*STEP high cycles per period.
- pwm  output  1: PWM waveform.
- count  output  16: current period counter value, 0..PERIOD-1.
- maxbitwidth  output  1: high for one cycle when count == PERIOD-1 (terminal count).

Behaviour:
- Clocking and reset:
  - One clock (`clk`).
  - Reset `rst` is synchronous and active-high.
  - All state updates on the rising edge of clk.
- Reset (rst=1 at a clock edge):
  - count=0, duty_active=0.
  - Hence pwm=0 and maxbitwidth=0 in the following cycle.
  - Held for as long as rst=1, regardless of mode.
  - Reset asserted mid-period aborts the period immediately; no partial pulse after release.
- Counter:
  - count increments by 1 each cycle.
  - At PERIOD-1 it wraps to 0 on the next edge.
  - Free-running in every mode, including mode 0.
- Duty register (duty_active, 16 bits, internal):
  - Loaded with mode*STEP on the edge where count wraps PERIOD-1 → 0.
  - Otherwise holds its value.
  - Mode changes mid-period therefore take effect at the next period start; no runt or stretched pulses.
  - After reset release, the first period uses duty 0 (pwm low). The mode is sampled at the end of that first period.
- pwm:
  - pwm == (count < duty_active) in every cycle, with both quantities registered, so pwm is glitch-free.
  - Implement as a register computed from next-state values, or as a compare of registered signals feeding a registered output that is cycle-aligned to count.
  - mode 0 → pwm constantly 0.
  - mode 15 with PERIOD = 16*STEP → high 15/16 of the period.
  - duty_active never reaches PERIOD, so there is never a 100% duty cycle unless PERIOD < 16*STEP, which the parameter check forbids.
- maxbitwidth:
  - == (count == PERIOD-1), cycle-aligned with count.
  - Exactly one cycle high per period.
  - 0 during reset.
- Widths:
  - mode*STEP is computed in 16 bits.
  - With STEP ≤ PERIOD/16 the product cannot overflow.
- Simultaneous events:
  - rst has priority over the wrap/load.
  - A mode change on the wrap edge: the value sampled at that edge is used.

Decomposition:
- Shared package `pulse_generator_pkg`:
  - Default constants PWM_STEP=4 and PWM_PERIOD=64.
  - Counter width constant CNT_W=16.
- One natural sub-module, `pwm_period_counter`:
  - Contains the counter, wrap logic and terminal-count strobe.
  - Outputs count and maxbitwidth.
  - The top level holds the duty register, the mode scaling and the pwm compare.

Test Plan (defaults STEP=4, PERIOD=64):
1. Reset hold: rst=1, mode=4 for 150 cycles → count=0, pwm=0, maxbitwidth=0 throughout.
2. Mode 1 after reset release:
   - First 64 cycles: pwm=0.
   - Every following period: pwm high for count 0..3 (4 cycles), low for 60.
   - maxbitwidth pulses once per 64 cycles at count=63.
3. Mode switch 1→2 mid-period (at count=20):
   - Current period finishes with a 4-cycle high.
   - The next period shows an 8-cycle high.
   - No extra edges.
4. Modes 3 and 4 → high times of 12 and 16 cycles per 64-cycle period. Mode 0 → pwm stays 0 while count keeps cycling 0..63.
5. Mode 15 → high 60 cycles, low 4. Wrap check: count goes 63→0 with maxbitwidth=1 exactly at 63.
6. Reset asserted at count=2 during a mode-4 high phase → next cycle count=0, pwm=0. After release, one full low period, then a 16-cycle high.
